// File: rtl/up_sync_counter.sv
// Synchronous up counter built from per-bit T flip-flops driven by an AND-chain toggle network.
// Optional parallel load is compiled in when UP_CNT_LOAD_EN is defined.
module up_sync_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] chain;
    logic             at_max;
    logic             wrap_d;

    assign at_max = (q == MaxVal);
    assign tc     = en & at_max;

    // Bit i toggles when enabled and all lower bits are set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        if (i == 0) begin : g_lsb
            assign chain[i] = en;
        end else begin : g_upper
            assign chain[i] = en & (&q[i-1:0]);
        end
    end

`ifdef UP_CNT_LOAD_EN
    logic [WIDTH-1:0] dsel;
    assign dsel = (d > MaxVal) ? MaxVal : d;
`else
    logic unused_load;
    assign unused_load = ^{load, d};
`endif

    always_comb begin
        t      = '0;
        wrap_d = 1'b0;
        if (clr) begin
            t = q;
`ifdef UP_CNT_LOAD_EN
        end else if (load) begin
            t = q ^ dsel;
`endif
        end else if (en) begin
            if (at_max) begin
                // Toggling every set bit lands on zero for any MAX.
                t      = q;
                wrap_d = 1'b1;
            end else begin
                t = chain;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q[i] <= 1'b0;
            end else begin
                q[i] <= q[i] ^ t[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_d;
        end
    end

endmodule

// File: doc/up_sync_counter.md
# up_sync_counter

Synchronous binary up counter built structurally from T flip-flops with an AND-chain toggle network, parameterised in width and terminal value. It is the counting-up counterpart to the team's synchronous down counter and shares its clock/reset naming and its T-flip-flop primitive style. Used as a cycle/event counter and modulus divider. Provides terminal-count and wrap indications for cascading.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- MAX, 2**WIDTH-1, terminal value. The count runs 0..MAX and then wraps to 0. Legal range 1..2**WIDTH-1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load; only functional with UP_CNT_LOAD_EN.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count.
- tc  output  1  terminal count, combinational: en & (q == MAX).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a MAX->0 transition caused by counting.

## Operation
- Storage: WIDTH T flip-flops, one per bit, each with async active-low reset to 0.
- Toggle network:
  - t[0] = en.
  - t[i] = en & q[0] & ... & q[i-1].
  - When q == MAX and MAX < 2**WIDTH-1, the toggle vector is chosen so the next state is 0: t = q.
- Next-state priority, evaluated per rising edge, highest first:
  - clr: q <= 0; wrap <= 0.
  - load (macro enabled only): q <= d when d <= MAX, else q <= MAX; wrap <= 0.
  - en: q <= (q == MAX) ? 0 : q + 1; wrap <= (q == MAX).
  - Otherwise hold q; wrap <= 0.
- Arithmetic is modulo MAX+1. There is no overflow beyond MAX and no values outside 0..MAX in normal operation.
- tc depends only on en and q. It rises in the same cycle the count reaches MAX if en is high. This allows tc of one instance to drive en of the next.
- Simultaneous events:
  - clr with en at MAX: clear wins and wrap stays 0.
  - load with en: load wins.
- Reset while asserted:
  - q = 0, wrap = 0.
  - tc = 0 unless MAX == 0, which is illegal.
  - Deassertion mid-operation restarts counting from 0 on the first enabled edge.

## Timing
- Reset values: q = 0, wrap = 0, tc = 0 (tc follows en & (q == MAX)).
- Latency:
  - en to q: one clock.
  - clr/load to q: one clock.
  - MAX->0 wrap to wrap output: wrap is high for exactly the one cycle following the wrapping edge.
- reset acts immediately, independent of clk. Release is expected synchronous to clk; the first count occurs on the first rising edge with en = 1 after release.
- tc is a combinational path from en and q. Consumers must register it or use it as a same-cycle enable only.
- Continuous en gives period MAX+1 cycles and exactly one wrap pulse per period.

## Configuration
- UP_CNT_LOAD_EN defined:
  - The load/d path is compiled in as described under Operation.
  - Implemented as a per-bit T input t[i] = q[i] ^ dsel[i], where dsel is the clamped load value.
- UP_CNT_LOAD_EN undefined:
  - load and d ports remain on the interface but are ignored.
  - No load logic is synthesised.
  - Priority reduces to clr > en > hold.

## Test plan
- Reset: hold reset=0 for 3 cycles with en=1 -> q=0, wrap=0, tc=0 throughout. Release, then 5 enabled edges -> q=5.
- Full count, WIDTH=4 default MAX=15, en=1 for 17 cycles from 0:
  - q steps 0..15, 0, 1.
  - tc=1 only while q=15.
  - wrap=1 only in the cycle q=0 following 15.
- Modulus, WIDTH=4, MAX=9, en=1:
  - Sequence 0..9, 0 repeating.
  - q never shows 10..15.
  - wrap every 10 cycles.
- Enable gating: en toggles 1,0,1,0 from q=3 -> q = 4, 4, 5, 5. tc stays 0.
- Priority:
  - At q=15 with clr=1, en=1 -> q=0 and wrap=0 next cycle.
  - With UP_CNT_LOAD_EN, MAX=9:
    - load=1, d=7, en=1 -> q=7.
    - load=1, d=12 -> q=9.
- Async reset mid-count: at q=11, drop reset between clock edges -> q=0 immediately, before the next edge. Release -> counting resumes 1, 2, ...
